// File: rtl/gate_trainer_sequencer.sv
// Sweeps the trainer gate array through {a,b} = 00..11 with a programmable dwell, capturing
// the seven gate outputs per vector. Define TRAINER_SELFCHECK_EN to add pass/fail_mask checking.
module gate_trainer_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [6:0]         gate_in,
  output logic               a,
  output logic               b,
  output logic [1:0]         vec_idx,
  output logic               busy,
  output logic               done,
  output logic               cap_valid,
  output logic [6:0]         cap_data
`ifdef TRAINER_SELFCHECK_EN
  ,
  output logic               pass,
  output logic [3:0]         fail_mask
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSample,
    StWaitStep,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               cap_valid_q, cap_valid_d;
  logic [6:0]         cap_data_q, cap_data_d;
  logic [DWELL_W-1:0] cnt_load;

  // A dwell of zero behaves as one.
  assign cnt_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

`ifdef TRAINER_SELFCHECK_EN
  localparam logic [3:0][6:0] Expected = {7'h61, 7'h2A, 7'h3A, 7'h1D};

  logic       pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
`endif

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    cap_valid_d = 1'b0;
    cap_data_d  = cap_data_q;
`ifdef TRAINER_SELFCHECK_EN
    pass_d      = pass_q;
    fail_d      = fail_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StApply;
          vec_d   = 2'd0;
          cnt_d   = cnt_load;
`ifdef TRAINER_SELFCHECK_EN
          pass_d  = 1'b0;
          fail_d  = 4'b0000;
`endif
        end
      end
      StApply: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      StSample: begin
        cap_valid_d = 1'b1;
        cap_data_d  = gate_in;
`ifdef TRAINER_SELFCHECK_EN
        if (gate_in != Expected[vec_q]) begin
          fail_d[vec_q] = 1'b1;
        end
`endif
        if (vec_q == 2'd3) begin
          state_d = StDone;
`ifdef TRAINER_SELFCHECK_EN
          pass_d  = (fail_d == 4'b0000);
`endif
        end else if (step_mode) begin
          state_d = StWaitStep;
        end else begin
          state_d = StApply;
          vec_d   = vec_q + 2'd1;
          cnt_d   = cnt_load;
        end
      end
      StWaitStep: begin
        if (step) begin
          state_d = StApply;
          vec_d   = vec_q + 2'd1;
          cnt_d   = cnt_load;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      vec_q       <= 2'd0;
      cnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= 7'd0;
`ifdef TRAINER_SELFCHECK_EN
      pass_q      <= 1'b0;
      fail_q      <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
`ifdef TRAINER_SELFCHECK_EN
      pass_q      <= pass_d;
      fail_q      <= fail_d;
`endif
    end
  end

  assign vec_idx   = vec_q;
  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = (state_q == StApply) || (state_q == StSample) || (state_q == StWaitStep);
  assign done      = (state_q == StDone);
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
`ifdef TRAINER_SELFCHECK_EN
  assign pass      = pass_q;
  assign fail_mask = fail_q;
`endif

endmodule

// File: tb/tb_gate_trainer_sequencer.sv
// Randomized self-checking bench for gate_trainer_sequencer; expectations come from cycle
// arithmetic over the run timeline plus a truth-table model of the trainer.
module tb_gate_trainer_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, step_mode, step;
  logic [DW-1:0] dwell;
  logic [6:0]    gate_in, stuck0;
  logic          a, b, busy, done, cap_valid;
  logic [1:0]    vec_idx;
  logic [6:0]    cap_data;
`ifdef TRAINER_SELFCHECK_EN
  logic          pass;
  logic [3:0]    fail_mask;
`endif

  int total = 0;
  int bad   = 0;

  // Golden gate values per vector, independent of the trainer model below.
  logic [6:0] golden [4] = '{7'h1D, 7'h3A, 7'h2A, 7'h61};

  function automatic logic [6:0] trainer(input logic [1:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
  endfunction

  assign gate_in = trainer({a, b}) & ~stuck0;

  logic [6:0] st;
  assign st = {a, b, vec_idx, busy, done, cap_valid};

  always #5 clk = ~clk;

  gate_trainer_sequencer #(.DWELL_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step_mode(step_mode),
    .step     (step),
    .dwell    (dwell),
    .gate_in  (gate_in),
    .a        (a),
    .b        (b),
    .vec_idx  (vec_idx),
    .busy     (busy),
    .done     (done),
    .cap_valid(cap_valid),
    .cap_data (cap_data)
`ifdef TRAINER_SELFCHECK_EN
    ,
    .pass     (pass),
    .fail_mask(fail_mask)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] mask_for(input logic [6:0] fault);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = ((trainer(2'(i)) & ~fault) != golden[i]);
    return m;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    total++;
    if (st !== 7'd0 || cap_data !== 7'd0) begin
      bad++;
      $display("FAIL reset status got=%b/%h want=0/0", st, cap_data);
    end
`ifdef TRAINER_SELFCHECK_EN
    total++;
    if (pass !== 1'b0 || fail_mask !== 4'd0) begin
      bad++;
      $display("FAIL reset_check got pass=%b mask=%b want 0/0000", pass, fail_mask);
    end
`endif
    rst = 1'b0;
    tick;
  endtask

  // Auto run: vector i occupies cycles [i*(D+1), (i+1)*(D+1)) after E0, DONE at 4*(D+1).
  task automatic run_auto(input int d_in, input logic [6:0] fault, input bit hold_start,
                          input string name);
    int         d, period, n;
    logic [1:0] ev;
    logic [6:0] exp_st;
    logic [3:0] exp_mask;
    d        = (d_in == 0) ? 1 : d_in;
    period   = d + 1;
    n        = 4 * period;
    exp_mask = mask_for(fault);
    step_mode = 1'b0;
    stuck0    = fault;
    dwell     = DW'(d_in);
    start     = 1'b1;
    tick;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k <= n; k++) begin
      ev     = (k < n) ? 2'(k / period) : 2'd3;
      exp_st = {ev[1], ev[0], ev, k < n, k == n, (k > 0) && (k % period == 0)};
      total++;
      if (st !== exp_st) begin
        bad++;
        $display("FAIL %s status k=%0d got=%b want=%b", name, k, st, exp_st);
      end
      if (exp_st[0]) begin
        total++;
        if (cap_data !== (trainer(2'(k / period - 1)) & ~fault)) begin
          bad++;
          $display("FAIL %s cap_data k=%0d got=%h want=%h", name, k, cap_data,
                   trainer(2'(k / period - 1)) & ~fault);
        end
      end
      if (k < n) begin
        // dwell only matters on the load edge leaving SAMPLE; scramble it elsewhere
        dwell = (k % period == d) ? DW'(d_in) : DW'($urandom_range(0, 255));
        tick;
      end
    end
    dwell = DW'(d_in);
`ifdef TRAINER_SELFCHECK_EN
    total++;
    if (fail_mask !== exp_mask || pass !== (exp_mask == 4'd0)) begin
      bad++;
      $display("FAIL %s selfcheck got pass=%b mask=%b want pass=%b mask=%b", name, pass,
               fail_mask, exp_mask == 4'd0, exp_mask);
    end
`endif
    tick;
    total++;
    if (st !== 7'b1111000) begin
      bad++;
      $display("FAIL %s idle_hold got=%b want=1111000", name, st);
    end
    if (hold_start) begin
      tick;
      total++;
      if (st !== 7'b0000100) begin
        bad++;
        $display("FAIL %s restart got=%b want=0000100", name, st);
      end
      start = 1'b0;
    end
  endtask

  task automatic test_manual;
    int         d, w_len;
    logic [1:0] iv;
    logic [6:0] exp_st;
    d         = 2;
    dwell     = DW'(d);
    stuck0    = 7'd0;
    step_mode = 1'b1;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv = 2'(i);
      for (int j = 0; j <= d; j++) begin
        exp_st = {iv[1], iv[0], iv, 3'b100};
        total++;
        if (st !== exp_st) begin
          bad++;
          $display("FAIL manual_apply i=%0d j=%0d got=%b want=%b", i, j, st, exp_st);
        end
        step      = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
        step_mode = (j == d) ? 1'b1 : 1'($urandom_range(0, 1));
        tick;
      end
      step  = 1'b0;
      start = 1'b0;
      if (i < 3) begin
        w_len = $urandom_range(1, 5);
        for (int w = 0; w < w_len; w++) begin
          exp_st = {iv[1], iv[0], iv, 1'b1, 1'b0, w == 0};
          total++;
          if (st !== exp_st) begin
            bad++;
            $display("FAIL manual_wait i=%0d w=%0d got=%b want=%b", i, w, st, exp_st);
          end
          if (w == 0) begin
            total++;
            if (cap_data !== golden[i]) begin
              bad++;
              $display("FAIL manual_cap i=%0d got=%h want=%h", i, cap_data, golden[i]);
            end
          end
          step = (w == w_len - 1);
          tick;
        end
        step = 1'b0;
      end
    end
    total++;
    if (st !== 7'b1111011 || cap_data !== golden[3]) begin
      bad++;
      $display("FAIL manual_done got=%b/%h want=1111011/%h", st, cap_data, golden[3]);
    end
`ifdef TRAINER_SELFCHECK_EN
    total++;
    if (pass !== 1'b1 || fail_mask !== 4'd0) begin
      bad++;
      $display("FAIL manual_selfcheck got pass=%b mask=%b want 1/0000", pass, fail_mask);
    end
`endif
    step_mode = 1'b0;
    tick;
  endtask

  task automatic test_start_held_reset_mid_run;
    bit found;
    run_auto(3, 7'h10, 1'b1, "held");
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (vec_idx == 2'd2) found = 1'b1;
      else tick;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midrun_wait got=timeout want=vec_idx 2");
    end
    rst = 1'b1;
    tick;
    total++;
    if (st !== 7'd0 || cap_data !== 7'd0) begin
      bad++;
      $display("FAIL midrun_reset got=%b/%h want=0/0", st, cap_data);
    end
`ifdef TRAINER_SELFCHECK_EN
    total++;
    if (pass !== 1'b0 || fail_mask !== 4'd0) begin
      bad++;
      $display("FAIL midrun_reset_check got pass=%b mask=%b want 0/0000", pass, fail_mask);
    end
`endif
    rst = 1'b0;
    tick;
    total++;
    if (st !== 7'd0) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=0", st);
    end
    run_auto(1, 7'd0, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    logic [6:0] f;
    for (int r = 0; r < 4; r++) begin
      f = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
      run_auto($urandom_range(0, 6), f, 1'b0, "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    dwell     = '0;
    stuck0    = 7'd0;
    tick;
    test_reset;
    run_auto(3, 7'd0, 1'b0, "auto_d3");
    run_auto(0, 7'd0, 1'b0, "dwell0");
    run_auto(1, 7'd0, 1'b0, "dwell1");
    test_manual;
    run_auto(2, 7'h02, 1'b0, "xor_stuck");
    test_start_held_reset_mid_run;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
